// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
// Shared definitions for the fetch stage.
//   fetchState_t : fetch sequencer states
//   XLEN         : architectural register / address width
//   NOP          : canonical no-op encoding (addi x0, x0, 0), used by decode
//                  to fill squashed F/D slots
package fetch_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    FETCH_BOOT    = 2'd0,
    FETCH_FETCH   = 2'd1,
    FETCH_HOLD    = 2'd2,
    FETCH_DISCARD = 2'd3
  } fetchState_t;

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Fetch-stage sequencer. Drives the PC load enable and the instruction-bus
// request, captures fetched words into the F/D register, holds them while
// decode is stalled, and squashes in-flight fetches on a taken branch.
//
// Parameters
//   BOOT_CYCLES : cycles after reset release before the first request (>=1)
//   TIMEOUT     : no-ack wait cycles before o_BusErr is raised (1..255)
//
// Ports
//   i_Clk          clock, rising edge
//   i_Rst          synchronous active-high reset
//   i_Stall        decode cannot accept a new instruction
//   i_TakeBranch   taken branch/jump resolved in M this cycle
//   i_Pc           current PC
//   i_IBusAck      instruction bus ack, i_IBusRdata valid
//   i_IBusRdata    instruction word
//   o_PcEn         PC load enable (combinational)
//   o_IBusReq      fetch request
//   o_IBusAddr     fetch address
//   o_Instr_F      captured instruction (registered)
//   o_InstrValid_F o_Instr_F holds a live instruction (registered)
//   o_Flush        squash F/D and D/E (combinational)
//   o_BusErr       sticky fetch-timeout flag
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic            i_Clk,
  input  logic            i_Rst,
  input  logic            i_Stall,
  input  logic            i_TakeBranch,
  input  logic [XLEN-1:0] i_Pc,
  input  logic            i_IBusAck,
  input  logic [XLEN-1:0] i_IBusRdata,
  output logic            o_PcEn,
  output logic            o_IBusReq,
  output logic [XLEN-1:0] o_IBusAddr,
  output logic [XLEN-1:0] o_Instr_F,
  output logic            o_InstrValid_F,
  output logic            o_Flush,
  output logic            o_BusErr
);

  localparam int              BOOT_W      = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);
  localparam logic [BOOT_W-1:0] BOOT_INIT = BOOT_W'(BOOT_CYCLES);
  localparam logic [7:0]      TIMEOUT_LIM = 8'(TIMEOUT);

  function automatic logic [7:0] satInc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  fetchState_t       r_State;
  fetchState_t       nextState;
  logic [BOOT_W-1:0] r_BootCnt;
  logic [7:0]        r_WaitCnt;
  logic [7:0]        waitNext;
  logic [XLEN-1:0]   r_ReqAddr;
  logic [XLEN-1:0]   r_Instr;
  logic              r_Valid;
  logic              validNext;
  logic              r_BusErr;
  logic              pcEn;
  logic              req;
  logic [XLEN-1:0]   addr;
  logic              capture;
  logic              latchAddr;

  always_comb begin
    nextState = r_State;
    pcEn      = 1'b0;
    req       = 1'b0;
    addr      = i_Pc;
    capture   = 1'b0;
    latchAddr = 1'b0;
    case (r_State)
      FETCH_BOOT: begin
        if (r_BootCnt <= BOOT_W'(1)) nextState = FETCH_FETCH;
      end
      FETCH_FETCH: begin
        req = 1'b1;
        // A taken branch is older than anything decode is doing, so it wins
        // over stall; the word arriving this cycle (if any) is wrong-path.
        if (i_TakeBranch) begin
          pcEn = 1'b1;
          if (!i_IBusAck) begin
            // Request is still outstanding: keep it pinned to its original
            // address while the PC moves on to the target.
            latchAddr = 1'b1;
            nextState = FETCH_DISCARD;
          end
        end else if (i_IBusAck) begin
          capture = 1'b1;
          if (i_Stall) nextState = FETCH_HOLD;
          else         pcEn      = 1'b1;
        end
      end
      FETCH_HOLD: begin
        if (i_TakeBranch || !i_Stall) begin
          pcEn      = 1'b1;
          nextState = FETCH_FETCH;
        end
      end
      FETCH_DISCARD: begin
        req  = 1'b1;
        addr = r_ReqAddr;
        if (i_TakeBranch) pcEn = 1'b1;
        if (i_IBusAck) nextState = FETCH_FETCH;
      end
      default: nextState = FETCH_BOOT;
    endcase
  end

  always_comb begin
    if (capture)                     validNext = 1'b1;
    else if (i_TakeBranch || !i_Stall) validNext = 1'b0;
    else                             validNext = r_Valid;
  end

  always_comb begin
    if (req) waitNext = i_IBusAck ? 8'd0 : satInc(r_WaitCnt);
    else     waitNext = r_WaitCnt;
  end

  // Stage boundary: sequencer state and F/D register
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State   <= FETCH_BOOT;
      r_BootCnt <= BOOT_INIT;
      r_WaitCnt <= 8'd0;
      r_Valid   <= 1'b0;
      r_BusErr  <= 1'b0;
      r_Instr   <= '0;
    end else begin
      r_State   <= nextState;
      if (r_State == FETCH_BOOT && r_BootCnt != '0) r_BootCnt <= r_BootCnt - BOOT_W'(1);
      r_WaitCnt <= waitNext;
      r_Valid   <= validNext;
      if (waitNext >= TIMEOUT_LIM) r_BusErr <= 1'b1;
      if (capture) r_Instr <= i_IBusRdata;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (latchAddr) r_ReqAddr <= i_Pc;
  end

  // Reset overrides the combinational handshake so the PC does not advance
  // and an outstanding request is dropped in the reset cycle itself.
  assign o_PcEn         = pcEn & ~i_Rst;
  assign o_IBusReq      = req & ~i_Rst;
  assign o_IBusAddr     = addr;
  assign o_Instr_F      = r_Instr;
  assign o_InstrValid_F = r_Valid;
  assign o_Flush        = i_TakeBranch;
  assign o_BusErr       = r_BusErr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
// Directed bench for fetch_ctrl (BOOT_CYCLES=2, TIMEOUT=4). The bench owns a
// small PC model and a combinational instruction memory; ack, stall and
// branch are driven per cycle and outputs are checked 2 time units after
// each rising edge.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b0;
  logic        i_Stall = 1'b0;
  logic        i_TakeBranch = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        i_IBusAck = 1'b0;
  logic [31:0] i_IBusRdata;
  logic        o_PcEn;
  logic        o_IBusReq;
  logic [31:0] o_IBusAddr;
  logic [31:0] o_Instr_F;
  logic        o_InstrValid_F;
  logic        o_Flush;
  logic        o_BusErr;

  logic        pcLoad = 1'b0;
  logic [31:0] pcLoadVal = 32'h0;
  logic [31:0] brTarget = 32'h0;

  int total = 0;
  int bad   = 0;

  fetch_ctrl #(.BOOT_CYCLES(2), .TIMEOUT(4)) dut (
    .i_Clk          (i_Clk),
    .i_Rst          (i_Rst),
    .i_Stall        (i_Stall),
    .i_TakeBranch   (i_TakeBranch),
    .i_Pc           (pc),
    .i_IBusAck      (i_IBusAck),
    .i_IBusRdata    (i_IBusRdata),
    .o_PcEn         (o_PcEn),
    .o_IBusReq      (o_IBusReq),
    .o_IBusAddr     (o_IBusAddr),
    .o_Instr_F      (o_Instr_F),
    .o_InstrValid_F (o_InstrValid_F),
    .o_Flush        (o_Flush),
    .o_BusErr       (o_BusErr)
  );

  always #5 i_Clk = ~i_Clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h00: return 32'h00000013;
      32'h04: return 32'h00100093;
      32'h08: return 32'h00000093;
      32'h0C: return 32'h00200113;
      32'h10: return 32'hDEAD0010;
      32'h40: return 32'h00400213;
      32'h80: return 32'h00500293;
      default: return {a[15:0], 16'hBEEF};
    endcase
  endfunction

  always_comb i_IBusRdata = memWord(o_IBusAddr);

  always @(posedge i_Clk) begin
    if (pcLoad)      pc <= pcLoadVal;
    else if (o_PcEn) pc <= i_TakeBranch ? brTarget : pc + 32'd4;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic br, input logic ack);
    @(posedge i_Clk);
    #1;
    i_Stall      = st;
    i_TakeBranch = br;
    i_IBusAck    = ack;
    #1;
  endtask

  task automatic doReset(input logic [31:0] startPc);
    @(posedge i_Clk);
    #1;
    i_Rst = 1'b1; i_Stall = 1'b0; i_TakeBranch = 1'b0; i_IBusAck = 1'b0;
    pcLoad = 1'b1; pcLoadVal = startPc;
    @(posedge i_Clk);
    @(posedge i_Clk);
    #1;
    i_Rst = 1'b0; pcLoad = 1'b0;
    #1;
  endtask

  initial begin
    // Boot and zero-wait streaming
    doReset(32'h0);
    chk("rst_req",   32'(o_IBusReq), 32'd0);
    chk("rst_pcen",  32'(o_PcEn), 32'd0);
    chk("rst_valid", 32'(o_InstrValid_F), 32'd0);
    chk("rst_instr", o_Instr_F, 32'h0);
    chk("rst_err",   32'(o_BusErr), 32'd0);
    chk("rst_state", 32'(dut.r_State), 32'(FETCH_BOOT));
    drive(0, 0, 1);
    chk("boot1_req", 32'(o_IBusReq), 32'd0);
    drive(0, 0, 1);
    chk("c2_req",    32'(o_IBusReq), 32'd1);
    chk("c2_addr",   o_IBusAddr, 32'h0);
    chk("c2_pcen",   32'(o_PcEn), 32'd1);
    drive(0, 0, 1);
    chk("c3_addr",   o_IBusAddr, 32'h4);
    chk("c3_instr",  o_Instr_F, 32'h00000013);
    chk("c3_valid",  32'(o_InstrValid_F), 32'd1);
    chk("c3_pcen",   32'(o_PcEn), 32'd1);

    // Stall for 3 cycles starting with the ack of the word at 0x8
    drive(1, 0, 1);
    chk("s0_addr",   o_IBusAddr, 32'h8);
    chk("s0_instr",  o_Instr_F, 32'h00100093);
    chk("s0_pcen",   32'(o_PcEn), 32'd0);
    drive(1, 0, 0);
    chk("s1_state",  32'(dut.r_State), 32'(FETCH_HOLD));
    chk("s1_req",    32'(o_IBusReq), 32'd0);
    chk("s1_pcen",   32'(o_PcEn), 32'd0);
    chk("s1_instr",  o_Instr_F, 32'h00000093);
    chk("s1_valid",  32'(o_InstrValid_F), 32'd1);
    drive(1, 0, 0);
    chk("s2_pcen",   32'(o_PcEn), 32'd0);
    chk("s2_instr",  o_Instr_F, 32'h00000093);
    drive(0, 0, 0);
    chk("s3_pcen",   32'(o_PcEn), 32'd1);
    chk("s3_req",    32'(o_IBusReq), 32'd0);
    drive(0, 0, 1);
    chk("s4_req",    32'(o_IBusReq), 32'd1);
    chk("s4_addr",   o_IBusAddr, 32'hC);
    chk("s4_valid",  32'(o_InstrValid_F), 32'd0);

    // Branch while the fetch at 0x10 is outstanding; ack arrives 3 cycles later
    doReset(32'h10);
    brTarget = 32'h40;
    drive(0, 0, 0);
    drive(0, 1, 0);
    chk("b0_addr",   o_IBusAddr, 32'h10);
    chk("b0_pcen",   32'(o_PcEn), 32'd1);
    chk("b0_flush",  32'(o_Flush), 32'd1);
    drive(0, 0, 0);
    chk("b1_state",  32'(dut.r_State), 32'(FETCH_DISCARD));
    chk("b1_req",    32'(o_IBusReq), 32'd1);
    chk("b1_addr",   o_IBusAddr, 32'h10);
    chk("b1_pcen",   32'(o_PcEn), 32'd0);
    drive(0, 0, 0);
    chk("b2_addr",   o_IBusAddr, 32'h10);
    chk("b2_valid",  32'(o_InstrValid_F), 32'd0);
    drive(0, 0, 1);
    chk("b3_addr",   o_IBusAddr, 32'h10);
    chk("b3_flush",  32'(o_Flush), 32'd0);
    drive(1, 0, 1);
    chk("b4_addr",   o_IBusAddr, 32'h40);
    chk("b4_valid",  32'(o_InstrValid_F), 32'd0);
    chk("b4_instr",  o_Instr_F, 32'h0);

    // Branch and stall together while holding the 0x40 word
    brTarget = 32'h80;
    drive(1, 1, 0);
    chk("h0_instr",  o_Instr_F, 32'h00400213);
    chk("h0_valid",  32'(o_InstrValid_F), 32'd1);
    chk("h0_pcen",   32'(o_PcEn), 32'd1);
    chk("h0_flush",  32'(o_Flush), 32'd1);
    chk("h0_req",    32'(o_IBusReq), 32'd0);

    // Ack withheld: four wait cycles at 0x80 raise the sticky error
    drive(0, 0, 0);
    chk("h1_state",  32'(dut.r_State), 32'(FETCH_FETCH));
    chk("h1_valid",  32'(o_InstrValid_F), 32'd0);
    chk("h1_addr",   o_IBusAddr, 32'h80);
    chk("t0_err",    32'(o_BusErr), 32'd0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("t2_req",    32'(o_IBusReq), 32'd1);
    chk("t2_err",    32'(o_BusErr), 32'd0);
    drive(0, 0, 0);
    chk("t3_err",    32'(o_BusErr), 32'd0);
    drive(0, 0, 1);
    chk("t4_err",    32'(o_BusErr), 32'd1);
    chk("t4_req",    32'(o_IBusReq), 32'd1);
    drive(0, 0, 0);
    chk("t5_err",    32'(o_BusErr), 32'd1);
    chk("t5_instr",  o_Instr_F, 32'h00500293);
    chk("t5_valid",  32'(o_InstrValid_F), 32'd1);
    chk("t5_addr",   o_IBusAddr, 32'h84);

    // Reset in the middle of the outstanding request at 0x84
    @(posedge i_Clk);
    #1;
    i_Rst = 1'b1;
    #1;
    chk("r0_req",    32'(o_IBusReq), 32'd0);
    chk("r0_pcen",   32'(o_PcEn), 32'd0);
    @(posedge i_Clk);
    #1;
    i_Rst = 1'b0;
    #1;
    chk("r1_req",    32'(o_IBusReq), 32'd0);
    chk("r1_valid",  32'(o_InstrValid_F), 32'd0);
    chk("r1_err",    32'(o_BusErr), 32'd0);
    chk("r1_state",  32'(dut.r_State), 32'(FETCH_BOOT));
    drive(0, 0, 0);
    chk("r2_req",    32'(o_IBusReq), 32'd0);
    drive(0, 0, 0);
    chk("r3_req",    32'(o_IBusReq), 32'd1);
    chk("r3_addr",   o_IBusAddr, 32'h84);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
